// File: rtl/tff_chain_seq_pkg.sv
// Shared types and defaults for the cascaded T-flip-flop chain sequencer.
package tff_chain_seq_pkg;

    localparam int STAGES_DEF = 2;
    localparam int LEN_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/tff_chain_seq_if.sv
// Command and result handshakes of the chain sequencer; master drives commands
// and accepts results, slave is the sequencer itself.
interface tff_chain_seq_if
    import tff_chain_seq_pkg::*;
#(
    parameter int STAGES = STAGES_DEF,
    parameter int LEN_W  = LEN_W_DEF
);

    logic              cmd_valid;
    logic              cmd_ready;
    logic [LEN_W-1:0]  cmd_len;
    logic              cmd_data;
    logic              cmd_clr;
    logic              abort;
    logic              res_valid;
    logic              res_ready;
    logic [STAGES-1:0] res_q;
    logic              res_abort;
    logic              busy;

    modport master (
        output cmd_valid, cmd_len, cmd_data, cmd_clr, abort, res_ready,
        input  cmd_ready, res_valid, res_q, res_abort, busy
    );

    modport slave (
        input  cmd_valid, cmd_len, cmd_data, cmd_clr, abort, res_ready,
        output cmd_ready, res_valid, res_q, res_abort, busy
    );

endinterface

// File: rtl/tff_stage.sv
// Single T flip-flop with synchronous clear taking priority over the enabled toggle.
module tff_stage (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= 1'b0;
        end else if (clr) begin
            q <= 1'b0;
        end else if (en) begin
            q <= q ^ t;
        end
    end

endmodule

// File: rtl/tff_chain_seq.sv
// Sequencer that clocks an N-stage cascaded T-flip-flop chain for a commanded
// number of cycles and hands back the resulting chain snapshot.
module tff_chain_seq
    import tff_chain_seq_pkg::*;
#(
    parameter int STAGES = STAGES_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    tff_chain_seq_if.slave bus
);

    state_t            state;
    state_t            state_nxt;
    logic [LEN_W-1:0]  remaining;
    logic              data_q;
    logic              abort_q;
    logic [STAGES-1:0] chain;
    logic [STAGES-1:0] stage_t;
    logic              accept;
    logic              advance;
    logic              chain_clr;
    logic              done_ack;

    assign accept    = bus.cmd_valid && (state == IDLE);
    assign advance   = (state == RUN) && !bus.abort;
    assign chain_clr = accept && bus.cmd_clr;
    assign done_ack  = (state == DONE) && bus.res_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // An abort on the last run cycle still leaves via the abort path, so no advance happens.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (bus.cmd_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (bus.abort || (remaining == LEN_W'(1))) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            remaining <= '0;
            data_q    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            if (accept) begin
                remaining <= bus.cmd_len;
                data_q    <= bus.cmd_data;
            end else if (advance) begin
                remaining <= remaining - 1'b1;
            end

            if ((state == RUN) && bus.abort) begin
                abort_q <= 1'b1;
            end else if (done_ack) begin
                abort_q <= 1'b0;
            end
        end
    end

    assign stage_t[0] = data_q;
    if (STAGES > 1) begin : g_cascade
        assign stage_t[STAGES-1:1] = chain[STAGES-2:0];
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        tff_stage u_stage (
            .clk (clk),
            .rst (rst),
            .en  (advance),
            .clr (chain_clr),
            .t   (stage_t[k]),
            .q   (chain[k])
        );
    end

    assign bus.cmd_ready = (state == IDLE);
    assign bus.res_valid = (state == DONE);
    assign bus.res_q     = chain;
    assign bus.res_abort = abort_q;
    assign bus.busy      = (state != IDLE);

endmodule

// File: doc/tff_chain_seq.md
Name: tff_chain_seq

Overview:
- Command-driven sequencer for an N-stage cascaded toggle-flip-flop chain.
- Stage 0 toggles on the command data bit; stage k toggles on stage k-1's output.
- Accepts a run command (length, data bit, optional clear) over a valid/ready handshake and clocks the chain exactly that many cycles.
- Returns the chain snapshot over a second valid/ready handshake; a higher-level test/control block drives it.

Parameters:
- STAGES, 2, number of T-flip-flop stages in the chain (>=1).
- LEN_W, 8, width of the run-length field.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  high only in IDLE.
- cmd_len  input  LEN_W  number of chain advance cycles.
- cmd_data  input  1  T input applied to stage 0 during the run.
- cmd_clr  input  1  synchronously zero the chain on the accept edge.
- abort  input  1  terminate an active run.
- res_valid  output  1  result available; held until accepted.
- res_ready  input  1  result consumer ready.
- res_q  output  STAGES  chain state; bit k = stage k.
- res_abort  output  1  result came from an aborted run.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (rst low, async): state IDLE, chain = 0, remaining count = 0, latched data = 0. Outputs: cmd_ready=1 once released, res_valid=0, res_q=0, res_abort=0, busy=0.
- FSM has three states: IDLE, RUN, DONE.
- IDLE -> RUN on the accept edge (cmd_valid & cmd_ready) when cmd_len != 0. On that edge:
  - latch cmd_data;
  - load remaining = cmd_len;
  - clear the chain if cmd_clr=1, otherwise hold it. The chain does not advance on the accept edge.
- IDLE -> DONE on the accept edge when cmd_len == 0. The chain is cleared if cmd_clr=1, otherwise it is unchanged.
- On each RUN edge without abort, the chain advances:
  - stage0 <= stage0 ^ data;
  - stagek <= stagek ^ stage(k-1), using pre-edge values;
  - remaining decrements. The edge where remaining goes 1->0 advances the chain and moves to DONE.
- Latency: res_valid rises the cycle after edge cmd_len following the accept edge (cmd_len+1 cycles after accept). With cmd_len=0 it rises 1 cycle after accept.
- abort in RUN wins over advance: the chain does not advance on that edge, state moves to DONE, and res_abort is set. abort on the final RUN cycle also suppresses that advance.
- abort is ignored in IDLE and DONE.
- In DONE: res_valid=1, and res_q and res_abort are stable until the res_valid & res_ready edge.
  - On that edge: -> IDLE, res_abort cleared, chain retained (no auto-clear).
  - cmd_ready rises the following cycle; there is no same-cycle bypass.
- res_q always reflects the live chain register; the chain only changes in RUN and on clear.
- Command fields are sampled only on the accept edge; changes at other times are ignored.
- Reset asserted mid-run or mid-DONE discards the run and produces no result.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, RUN, DONE) with 2-bit encoding;
  - default constants STAGES_DEF=2 and LEN_W_DEF=8.
- One sub-module, tff_stage: a single T flip-flop with inputs clk, rst (async active-low), en, clr, t and output q. Priority is clr > en-toggle > hold.
- The top level instantiates STAGES of them in a generate loop plus the FSM and the down-counter.

Test Plan:
- Reset, then cmd_clr=1, cmd_data=1, cmd_len=3 -> res_valid 4 cycles after accept, res_q=2'b11, res_abort=0.
- From res_q=2'b11, cmd_clr=1, cmd_len=4, data=1 -> res_q=2'b00. With cmd_len=2 -> res_q=2'b10.
- Chain holds 2'b01 (stage0=1), cmd_clr=0, data=0, cmd_len=1 -> res_q=2'b11.
- cmd_len=0, cmd_clr=0 -> res_valid 1 cycle after accept, res_q unchanged. Hold res_ready low 5 cycles -> res_valid and res_q stable; cmd_ready=0 throughout.
- cmd_clr=1, data=1, len=10, abort pulsed on the 3rd RUN cycle -> 2 advances only, res_q=2'b10, res_abort=1.
- rst pulsed low mid-RUN, asynchronously between edges -> busy=0, res_valid=0, res_q=0 immediately. A new command after release runs normally.
